// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use and MUL/DIV stalls, taken-branch flush.
// Optional stall-cycle counter built when STALL_PERF_EN is defined.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [REG_AW-1:0] iIdRegRs,
    input  logic [REG_AW-1:0] iIdRegRt,
    input  logic              iIdUsesRt,
    input  logic              iIdMdOp,
    input  logic              iIdHiLoRead,
    input  logic              iExMemRead,
    input  logic [REG_AW-1:0] iExRegRt,
    input  logic              iBranchTaken,
    output logic              oPcWrite,
    output logic              oIfIdWrite,
    output logic              oIfIdFlush,
    output logic              oIdExBubble,
    output logic              oMdBusy,
    output logic [31:0]       oStallCycles
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu, md, stall, accept;

    always_comb begin
        lu = iExMemRead && (iExRegRt != '0) &&
             ((iExRegRt == iIdRegRs) ||
              (iIdUsesRt && (iExRegRt == iIdRegRt)));
        md = (state_q == BUSY) && (iIdMdOp || iIdHiLoRead);
        stall = (lu || md) && !iBranchTaken;
        accept = (state_q == IDLE) && iIdMdOp && !stall && !iBranchTaken;
    end

    // Reset forces a NOP into both pipeline registers regardless of hazards.
    always_comb begin
        oPcWrite    = 1'b1;
        oIfIdWrite  = 1'b1;
        oIfIdFlush  = 1'b0;
        oIdExBubble = 1'b0;
        oMdBusy     = (state_q == BUSY) && !iReset;
        if (iReset) begin
            oPcWrite    = 1'b0;
            oIfIdWrite  = 1'b0;
            oIfIdFlush  = 1'b1;
            oIdExBubble = 1'b1;
        end else if (iBranchTaken) begin
            oIfIdFlush  = 1'b1;
            oIdExBubble = 1'b1;
        end else if (stall) begin
            oPcWrite    = 1'b0;
            oIfIdWrite  = 1'b0;
            oIdExBubble = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CW'(MD_LATENCY);
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!oPcWrite && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign oStallCycles = perf_q;
`else
    assign oStallCycles = 32'h0;
`endif

endmodule
